neuron_weight_loader: RTL and testbench
=======================================

// Module: neuron_weight_loader
// PURPOSE
// - Write-side counterpart of the per-neuron weight ROMs (ROM_neuron data_i/wen_i port, non-Vivado builds).
// - Accepts a valid/ready stream of weight words for one layer and programs every neuron's memory in order.
// - Order: neuron 0 addr 0..DEPTH_WORDS-1, then neuron 1, and so on. Sits between the host/config interface and a layer.
// PARAMETERS
// - depth        3   address bits per neuron memory; DEPTH_WORDS = 2**depth
// - width        8   weight word width, bits
// - num_neurons  4   neuron memories in the layer; must be >= 1
// PORTS
// - clk_i         in   1                    clock, rising edge
// - reset_n_i     in   1                    asynchronous reset, active-low
// - start_i       in   1                    pulse: begin programming the layer
// - abort_i       in   1                    pulse: stop programming and return to IDLE
// - data_i        in   width                incoming weight word
// - valid_i       in   1                    data_i is valid
// - ready_o       out  1                    loader accepts data_i this cycle
// - addr_o        out  depth                write address to all neuron memories
// - data_o        out  width                write data to all neuron memories
// - wen_o         out  num_neurons          one-hot write enable, bit n = neuron n
// - busy_o        out  1                    high in LOAD
// - done_o        out  1                    one-cycle pulse after the last word is written
// - checksum_o    out  16                   only with WEIGHT_LOADER_CHECKSUM_EN
// BEHAVIOUR
// Reset
// - All outputs are 0 while reset_n_i = 0; the FSM is in IDLE.
// - Address and neuron counters are 0.
// FSM states: IDLE, LOAD, DONE
// - IDLE -> LOAD when start_i = 1. Counters clear to 0.
// - LOAD -> DONE when a word is accepted with addr_cnt = DEPTH_WORDS-1 and neuron_cnt = num_neurons-1.
// - LOAD -> IDLE when abort_i = 1. abort_i has priority over a same-cycle accept; that word is dropped.
// - DONE -> IDLE unconditionally. done_o = 1 during DONE only.
// - start_i is ignored in LOAD and DONE.
// Handshake
// - ready_o = (state == LOAD) && !abort_i. It is combinational from the state and abort_i.
// - Accept = valid_i && ready_o.
// - valid_i may be held or toggled freely; no words are taken outside LOAD.
// Write port (registered, 1-cycle latency)
// - The cycle after an accept: addr_o = addr_cnt and data_o = data_i as sampled at the accept.
// - In that same cycle, wen_o = 1 << neuron_cnt as sampled at the accept.
// - wen_o is 0 in every cycle that does not follow an accept.
// - addr_o and data_o hold their last values when wen_o = 0.
// Counters
// - addr_cnt increments on each accept.
// - At DEPTH_WORDS-1, addr_cnt wraps to 0 and neuron_cnt increments.
// - neuron_cnt never exceeds num_neurons-1.
// - Width of neuron_cnt is $clog2(num_neurons), minimum 1.
// Timing
// - The last write (wen_o pulse) coincides with the DONE cycle, so done_o is high in the same cycle as the final wen_o.
// - busy_o = (state == LOAD).
// Reset mid-operation
// - Reset clears everything immediately (asynchronous).
// - A partially programmed layer is left as-is; the host must restart with start_i.
// CONFIGURATION
// WEIGHT_LOADER_CHECKSUM_EN defined
// - checksum_o = 16-bit modulo-2^16 sum of zero-extended accepted words.
// - Cleared on start_i in IDLE and on reset.
// - Updated in the cycle after each accept, and held through DONE and IDLE.
// WEIGHT_LOADER_CHECKSUM_EN undefined
// - The checksum_o port and its logic are absent.
// TESTING
// - Reset: hold reset_n_i=0 with start_i=1, valid_i=1 -> all outputs 0, ready_o=0.
// - Full load (depth=3, num_neurons=4, continuous valid_i, data = index 0..31):
//   -> 32 wen_o pulses; neuron 2 addr 5 gets data 21; done_o one cycle, coincident with wen_o=4'b1000, addr_o=7.
// - Backpressure/gaps: valid_i toggled every other cycle -> same 32 writes in order, no duplicates, done_o once.
// - Abort after 10 accepts, with valid_i high that cycle -> word 11 not written, FSM returns to IDLE.
//   Following start_i restarts at neuron 0 addr 0.
// - Async reset asserted mid-LOAD, between clock edges -> outputs go to 0 at once; after release, ready_o=0 until start_i.
// - With WEIGHT_LOADER_CHECKSUM_EN, 32 words of 8'hFF -> checksum_o = 16'h1FE0 after DONE.
//   Without the macro, the bench compiles with no checksum_o.

Source files
------------

// File: rtl/neuron_weight_loader.sv
// Streams one layer of weight words into the per-neuron memories: neuron 0 addresses 0..2**depth-1 first, then neuron 1, and so on.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds checksum_o, a 16-bit running sum of the accepted words.
module neuron_weight_loader #(
    parameter int depth       = 3,
    parameter int width       = 8,
    parameter int num_neurons = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [width-1:0]       data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [depth-1:0]       addr_o,
    output logic [width-1:0]       data_o,
    output logic [num_neurons-1:0] wen_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]            checksum_o
`endif
);

    localparam int NCNT_W = (num_neurons > 1) ? $clog2(num_neurons) : 1;
    localparam logic [depth-1:0]  ADDR_LAST   = {depth{1'b1}};
    localparam logic [NCNT_W-1:0] NEURON_LAST = NCNT_W'(num_neurons - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [depth-1:0]         addr_cnt_q, addr_cnt_d;
    logic [NCNT_W-1:0]        neuron_cnt_q, neuron_cnt_d;
    logic [depth-1:0]         addr_q, addr_d;
    logic [width-1:0]         data_q, data_d;
    logic [num_neurons-1:0]   wen_q, wen_d;
    logic                     accept;

    // abort_i masks ready so an abort-cycle word is never taken
    assign ready_o = (state_q == S_LOAD) && !abort_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_LOAD;
                    addr_cnt_d   = '0;
                    neuron_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    if (addr_cnt_q == ADDR_LAST) begin
                        if (neuron_cnt_q == NEURON_LAST) begin
                            neuron_cnt_d = '0;
                            state_d      = S_DONE;
                        end else begin
                            neuron_cnt_d = neuron_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < num_neurons; gi++) begin : g_wen
            assign wen_d[gi] = accept && (neuron_cnt_q == NCNT_W'(gi));
        end
    endgenerate

    // Address/data hold their last written values between writes
    assign addr_d = accept ? addr_cnt_q : addr_q;
    assign data_d = accept ? data_i : data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            addr_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wen_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wen_q        <= wen_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign wen_o  = wen_q;
    assign busy_o = (state_q == S_LOAD);
    assign done_o = (state_q == S_DONE);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start_i) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + 16'(data_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Self-checking bench for neuron_weight_loader: table vectors, directed corner sequences and random traffic against a write-list model.
// Define WEIGHT_LOADER_CHECKSUM_EN on both files to exercise checksum_o.
module tb_neuron_weight_loader;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       start_i, abort_i, valid_i;
    logic [7:0] data_i;
    logic       ready_o, busy_o, done_o;
    logic [2:0] addr_o;
    logic [7:0] data_o;
    logic [3:0] wen_o;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] checksum_o;
`endif

    neuron_weight_loader #(.depth(3), .width(8), .num_neurons(4)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .wen_o      (wen_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum_o (checksum_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0=idle 1=loading 2=done; m_k = words accepted this load
    int          m_phase, m_k;
    logic [3:0]  e_wen;
    logic [2:0]  e_addr;
    logic [7:0]  e_data;
    logic [15:0] e_sum;
    logic        s_ready;

    logic [7:0]  mem [4][8];
    int          n_writes, n_done;
    logic [3:0]  d_wen;
    logic [2:0]  d_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_k = 0;
        e_wen = '0; e_addr = '0; e_data = '0; e_sum = '0;
    endtask

    task automatic clear_obs();
        n_writes = 0; n_done = 0; d_wen = '0; d_addr = '0;
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 8; a++)
                mem[n][a] = 8'h00;
    endtask

    // One clock cycle, entered and left on the falling edge
    task automatic cyc(input logic st, input logic ab, input logic vl, input logic [7:0] d);
        logic acc;
        start_i = st; abort_i = ab; valid_i = vl; data_i = d;
        #1;
        s_ready = ready_o;
        chk("ready", 32'(ready_o), 32'(m_phase == 1 && !ab));
        acc = vl && (m_phase == 1) && !ab;
        @(posedge clk_i);
        #1;
        if (acc) begin
            e_wen  = 4'(1 << (m_k / 8));
            e_addr = 3'(m_k % 8);
            e_data = d;
            e_sum  = e_sum + 16'(d);
            m_k++;
        end else begin
            e_wen = '0;
        end
        if (m_phase == 0) begin
            if (st) begin m_phase = 1; m_k = 0; e_sum = '0; end
        end else if (m_phase == 1) begin
            if (ab) m_phase = 0;
            else if (acc && m_k == 32) m_phase = 2;
        end else begin
            m_phase = 0;
        end
        chk("wen",  32'(wen_o),  32'(e_wen));
        chk("addr", 32'(addr_o), 32'(e_addr));
        chk("data", 32'(data_o), 32'(e_data));
        chk("busy", 32'(busy_o), 32'(m_phase == 1));
        chk("done", 32'(done_o), 32'(m_phase == 2));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("checksum", 32'(checksum_o), 32'(e_sum));
`endif
        for (int n = 0; n < 4; n++)
            if (wen_o[n]) mem[n][addr_o] = data_o;
        if (wen_o != 0) n_writes++;
        if (done_o) begin n_done++; d_wen = wen_o; d_addr = addr_o; end
        @(negedge clk_i);
    endtask

    typedef struct {
        logic       st, ab, vl;
        logic [7:0] d;
        logic       x_ready, x_busy;
        logic [3:0] x_wen;
        logic [2:0] x_addr;
        logic [7:0] x_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 4'h0, 3'd0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 4'h0, 3'd0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 4'h1, 3'd0, 8'hAA};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 4'h0, 3'd0, 8'hAA};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 4'h1, 3'd1, 8'h55};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 4'h0, 3'd1, 8'h55};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 4'h0, 3'd1, 8'h55};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 4'h0, 3'd1, 8'h55};

        // Reset held with start/valid asserted
        reset_n_i = 1'b0; start_i = 1'b1; abort_i = 1'b0; valid_i = 1'b1; data_i = 8'h5A;
        model_reset();
        clear_obs();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_wen",   32'(wen_o),   32'd0);
        chk("rst_addr",  32'(addr_o),  32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("rst_checksum", 32'(checksum_o), 32'd0);
`endif
        start_i = 1'b0; valid_i = 1'b0;
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Table vectors: idle ignores valid, start, accept, gap, start-in-load, abort, idle
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].vl, tbl[i].d);
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].x_ready));
            chk($sformatf("tbl%0d_busy", i),  32'(busy_o),  32'(tbl[i].x_busy));
            chk($sformatf("tbl%0d_wen", i),   32'(wen_o),   32'(tbl[i].x_wen));
            chk($sformatf("tbl%0d_addr", i),  32'(addr_o),  32'(tbl[i].x_addr));
            chk($sformatf("tbl%0d_data", i),  32'(data_o),  32'(tbl[i].x_data));
        end
        cyc(0, 1, 0, 8'h00);

        // Full load, continuous valid, data = index
        cyc(0, 0, 0, 8'h00);
        clear_obs();
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 8'(i));
        cyc(0, 0, 1, 8'hEE);
        cyc(0, 0, 0, 8'h00);
        chk("full_writes", 32'(n_writes), 32'd32);
        chk("full_done_cnt", 32'(n_done), 32'd1);
        chk("full_n2a5", 32'(mem[2][5]), 32'd21);
        chk("full_done_wen", 32'(d_wen), 32'h8);
        chk("full_done_addr", 32'(d_addr), 32'd7);

        // Gapped valid
        clear_obs();
        begin
            int idx = 0;
            cyc(1, 0, 0, 8'h00);
            for (int c = 0; c < 66; c++) begin
                if (c % 2 == 0 && idx < 32) begin cyc(0, 0, 1, 8'(idx + 64)); idx++; end
                else cyc(0, 0, 0, 8'hEE);
            end
        end
        chk("gap_writes", 32'(n_writes), 32'd32);
        chk("gap_done_cnt", 32'(n_done), 32'd1);
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 8; a++)
                chk($sformatf("gap_mem_n%0d_a%0d", n, a), 32'(mem[n][a]), 32'(n * 8 + a + 64));

        // Abort after 10 accepts with valid high, then restart
        clear_obs();
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'(100 + i));
        cyc(0, 1, 1, 8'd200);
        cyc(0, 0, 1, 8'd201);
        chk("abort_writes", 32'(n_writes), 32'd10);
        chk("abort_busy", 32'(busy_o), 32'd0);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 1, 8'd50);
        chk("restart_wen", 32'(wen_o), 32'h1);
        chk("restart_addr", 32'(addr_o), 32'd0);
        chk("restart_data", 32'(data_o), 32'd50);
        cyc(0, 1, 0, 8'h00);

        // Asynchronous reset between clock edges mid-load
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 8'(i + 1));
        valid_i = 1'b1;
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("arst_ready", 32'(ready_o), 32'd0);
        chk("arst_busy",  32'(busy_o),  32'd0);
        chk("arst_wen",   32'(wen_o),   32'd0);
        chk("arst_addr",  32'(addr_o),  32'd0);
        chk("arst_data",  32'(data_o),  32'd0);
        chk("arst_done",  32'(done_o),  32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        model_reset();
        cyc(0, 0, 1, 8'h99);
        cyc(0, 0, 1, 8'h98);

        // Checksum of 32 x FF
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 32; i++) cyc(0, 0, 1, 8'hFF);
        cyc(0, 0, 0, 8'h00);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk("checksum_ff", 32'(checksum_o), 32'h1FE0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 16) == 0, ($urandom % 40) == 0, $urandom % 2, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
